// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner: one digit is driven per slot of SCAN_DIV cycles.
// Each frame shows a snapshot of the inputs, with optional hex glyphs and leading-zero blanking.
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic                    blank_lz,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dots;
  logic                    snap_blz;

  logic                    tc;
  logic [3:0]              cur_code;
  logic                    cur_dot;
  logic                    cur_blank;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   an_next;

  // Active-low g..a pattern for one hex code.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = HEX_EN ? 7'b0001000 : 7'b1111111;
      4'hB:    s = HEX_EN ? 7'b0000011 : 7'b1111111;
      4'hC:    s = HEX_EN ? 7'b1000110 : 7'b1111111;
      4'hD:    s = HEX_EN ? 7'b0100001 : 7'b1111111;
      4'hE:    s = HEX_EN ? 7'b0000110 : 7'b1111111;
      default: s = HEX_EN ? 7'b0001110 : 7'b1111111;
    endcase
    return s;
  endfunction

  assign tc = (presc == LAST_PRE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset along with the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_dots   <= '0;
      snap_blz    <= 1'b0;
    end else if (!en) begin
      presc       <= '0;
      idx         <= '0;
      snap_digits <= digits;
      snap_dots   <= dots;
      snap_blz    <= blank_lz;
    end else begin
      presc <= tc ? '0 : presc + 1'b1;
      if (tc) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        // Frame boundary: latch fresh data so a frame never mixes old and new digits.
        if (idx == LAST_IDX) begin
          snap_digits <= digits;
          snap_dots   <= dots;
          snap_blz    <= blank_lz;
        end
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred;
  // zero_run is a blocking running flag, swept from the most-significant digit down.
  always_comb begin
    cur_code  = 4'h0;
    cur_dot   = 1'b0;
    cur_blank = 1'b0;
    zero_run  = snap_blz;
    an_next   = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (snap_digits[4*k +: 4] == 4'h0) && !snap_dots[k];
      if (idx == IDX_W'(k)) begin
        cur_code   = snap_digits[4*k +: 4];
        cur_dot    = snap_dots[k];
        cur_blank  = zero_run && (k > 0);
        an_next[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n      <= 8'hFF;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else if (!en) begin
      seg_n      <= 8'hFF;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg_n      <= {~cur_dot, cur_blank ? 7'b1111111 : decode(cur_code)};
      an_n       <= an_next;
      frame_tick <= (idx == '0) && (presc == '0);
    end
  end

endmodule
